// File: rtl/ssqa_controller.sv
// rtl/ssqa_controller.sv - annealing run sequencer for the SSQA core
//
// Sequences one annealing run: spin-memory reset, per-spin multiply/accumulate
// pipeline, spin update and per-sweep bookkeeping. Transitions are decided
// from the scheduler's registered counts seen during the current state.
//
// Optional feature macro: SSQA_CTRL_RUNCYC_EN (builds the run_cycles counter;
// without it run_cycles is tied to zero).
//
// Ports:
//   clk         system clock
//   rst_sys     asynchronous active-low reset
//   start       level request to begin a run (also holds FIN)
//   abort       return to IDLE from any state
//   iter_max    sweeps per run, 0 treated as 1
//   count_bit   scheduler spin-reset count
//   count_mult  scheduler multiply count
//   count_spin  scheduler spin index
//   count_iter  scheduler completed-sweep count
//   state       current state encoding, consumed by the scheduler
//   busy        run in progress
//   done        run finished (FIN)
//   acc_clr     accumulator clear
//   acc_en      accumulator enable
//   spin_we     spin-memory write enable
//   sweep_done  one-cycle pulse per completed sweep
//   run_cycles  busy-cycle count of the current/last run
module ssqa_controller #(
  parameter  int NN = 800,
  localparam int CW = $clog2(NN)
) (
  input  logic          clk,
  input  logic          rst_sys,
  input  logic          start,
  input  logic          abort,
  input  logic [15:0]   iter_max,
  input  logic [CW-1:0] count_bit,
  input  logic [CW-1:0] count_mult,
  input  logic [CW-1:0] count_spin,
  input  logic [15:0]   count_iter,
  output logic [3:0]    state,
  output logic          busy,
  output logic          done,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          spin_we,
  output logic          sweep_done,
  output logic [31:0]   run_cycles
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RESET   = 4'd1,
    STMULT  = 4'd2,
    MULT    = 4'd3,
    LMULT   = 4'd4,
    LLMULT  = 4'd5,
    LLLMULT = 4'd6,
    UPDATE  = 4'd7,
    LUPDATE = 4'd8,
    IRESET  = 4'd9,
    FIN     = 4'd10
  } state_e;

  localparam logic [CW-1:0] LAST_SPIN = CW'(NN - 1);
  localparam logic [CW-1:0] LAST_MULT = CW'(NN - 2);

  state_e      state_q, state_d;
  logic [15:0] iter_eff;

  // A zero sweep budget still runs one sweep.
  assign iter_eff = (iter_max == 16'd0) ? 16'd1 : iter_max;

  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && !abort) state_d = RESET;
        RESET:   if (count_bit == LAST_SPIN) state_d = STMULT;
        STMULT:  state_d = MULT;
        MULT:    if (count_mult == LAST_MULT) state_d = LMULT;
        LMULT:   state_d = LLMULT;
        LLMULT:  state_d = LLLMULT;
        LLLMULT: state_d = UPDATE;
        UPDATE:  state_d = (count_spin == LAST_SPIN) ? LUPDATE : STMULT;
        LUPDATE: state_d = IRESET;
        IRESET:  state_d = (count_iter >= iter_eff) ? FIN : STMULT;
        FIN:     if (!start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Decodes come from the state register only, so they are glitch-free
  // registered-equivalent signals for the datapath.
  always_comb begin
    busy       = (state_q != IDLE) && (state_q != FIN);
    done       = (state_q == FIN);
    acc_clr    = (state_q == STMULT);
    acc_en     = (state_q == STMULT) || (state_q == MULT) || (state_q == LMULT);
    spin_we    = (state_q == RESET) || (state_q == UPDATE);
    sweep_done = (state_q == LUPDATE);
  end

  assign state = state_q;

`ifdef SSQA_CTRL_RUNCYC_EN
  logic [31:0] run_cycles_q, run_cycles_d;

  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) run_cycles_q <= 32'd0;
    else          run_cycles_q <= run_cycles_d;
  end

  // Cleared on run launch; counts busy cycles so the value seen in FIN is the
  // run length from the first RESET cycle up to FIN.
  always_comb begin
    run_cycles_d = run_cycles_q;
    if ((state_q == IDLE) && (state_d == RESET)) begin
      run_cycles_d = 32'd0;
    end else if (busy && (run_cycles_q != 32'hFFFF_FFFF)) begin
      run_cycles_d = run_cycles_q + 32'd1;
    end
  end

  assign run_cycles = run_cycles_q;
`else
  assign run_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ssqa_controller.sv
// tb/tb_ssqa_controller.sv - scoreboard bench for ssqa_controller with a scheduler model
module tb_ssqa_controller;
  localparam int NN = 4;
  localparam int CW = $clog2(NN);

  localparam logic [3:0] S_IDLE = 4'd0, S_RESET = 4'd1, S_STMULT = 4'd2, S_MULT = 4'd3,
                         S_LMULT = 4'd4, S_LLMULT = 4'd5, S_LLLMULT = 4'd6, S_UPDATE = 4'd7,
                         S_LUPDATE = 4'd8, S_IRESET = 4'd9, S_FIN = 4'd10;

  logic          clk = 1'b0;
  logic          rst_sys, start, abort;
  logic [15:0]   iter_max;
  logic [CW-1:0] count_bit, count_mult, count_spin;
  logic [15:0]   count_iter;
  logic [3:0]    state;
  logic          busy, done, acc_clr, acc_en, spin_we, sweep_done;
  logic [31:0]   run_cycles;

  always #5 clk = ~clk;

  ssqa_controller #(.NN(NN)) dut (
    .clk(clk), .rst_sys(rst_sys), .start(start), .abort(abort), .iter_max(iter_max),
    .count_bit(count_bit), .count_mult(count_mult), .count_spin(count_spin),
    .count_iter(count_iter), .state(state), .busy(busy), .done(done),
    .acc_clr(acc_clr), .acc_en(acc_en), .spin_we(spin_we), .sweep_done(sweep_done),
    .run_cycles(run_cycles)
  );

  // Scheduler model: registered counts driven from the controller state.
  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) begin
      count_bit  <= '0;
      count_mult <= '0;
      count_spin <= '0;
      count_iter <= 16'd0;
    end else begin
      count_bit  <= (state == S_RESET) ? count_bit + CW'(1) : '0;
      count_mult <= (state == S_MULT) ? count_mult + CW'(1) : '0;
      if (state == S_RESET || state == S_LUPDATE) count_spin <= '0;
      else if (state == S_UPDATE)                 count_spin <= count_spin + CW'(1);
      if (state == S_RESET)        count_iter <= 16'd0;
      else if (state == S_LUPDATE) count_iter <= count_iter + 16'd1;
    end
  end

  typedef struct {logic [3:0] st; int dwell;} tr_t;
  typedef struct {int fin_lat; int sweeps; logic [31:0] runcyc;} run_t;
  tr_t  exp_q[$];
  run_t run_q[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // {busy, done, acc_clr, acc_en, spin_we, sweep_done}
  function automatic logic [5:0] exp_dec(logic [3:0] s);
    case (s)
      S_IDLE:                       return 6'b000000;
      S_RESET, S_UPDATE:            return 6'b100010;
      S_STMULT:                     return 6'b101100;
      S_MULT, S_LMULT:              return 6'b100100;
      S_LUPDATE:                    return 6'b100001;
      S_FIN:                        return 6'b010000;
      default:                      return 6'b100000;
    endcase
  endfunction

  task automatic push(logic [3:0] s, int d);
    tr_t t;
    t.st = s;
    t.dwell = d;
    exp_q.push_back(t);
  endtask

  task automatic push_spin_upto_update(int upd_dwell);
    push(S_STMULT, 1); push(S_MULT, NN - 1); push(S_LMULT, 1);
    push(S_LLMULT, 1); push(S_LLLMULT, 1); push(S_UPDATE, upd_dwell);
  endtask

  task automatic push_run(int sweeps, int fin_lat);
    run_t r;
    push(S_RESET, NN);
    for (int sw = 0; sw < sweeps; sw++) begin
      for (int sp = 0; sp < NN; sp++) push_spin_upto_update(1);
      push(S_LUPDATE, 1);
      push(S_IRESET, 1);
    end
    push(S_FIN, -1);
    push(S_IDLE, -1);
    r.fin_lat = fin_lat;
    r.sweeps  = sweeps;
`ifdef SSQA_CTRL_RUNCYC_EN
    r.runcyc  = 32'(fin_lat);
`else
    r.runcyc  = 32'd0;
`endif
    run_q.push_back(r);
  endtask

  task automatic wait_state(logic [3:0] s, int maxc, string nm);
    int n = 0;
    while (state !== s && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (state !== s) begin
      checks++;
      $display("FAIL timeout_%s: state %0d expected %0d", nm, state, s);
    end
  endtask

  // Monitor: pops the next expected transition whenever the state changes.
  initial begin
    logic [3:0] prev_st;
    int dwell, pend_dwell, cyc, reset_cyc, sweeps;
    tr_t t;
    run_t r;
    prev_st = S_IDLE; dwell = 0; pend_dwell = -1; cyc = 0; reset_cyc = 0; sweeps = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sweep_done) sweeps++;
      if (state !== prev_st) begin
        if (pend_dwell >= 0) chk($sformatf("dwell_st%0d", prev_st), 32'(dwell), 32'(pend_dwell));
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_transition: got state %0d expected no change", state);
          pend_dwell = -1;
        end else begin
          t = exp_q.pop_front();
          chk("state", 32'(state), 32'(t.st));
          chk($sformatf("decodes_st%0d", t.st),
              32'({busy, done, acc_clr, acc_en, spin_we, sweep_done}), 32'(exp_dec(t.st)));
          pend_dwell = t.dwell;
          if (t.st == S_RESET) begin
            reset_cyc = cyc;
            sweeps = 0;
          end
          if (t.st == S_FIN) begin
            if (run_q.size() == 0) begin
              checks++;
              $display("FAIL unexpected_fin: got FIN expected no run record");
            end else begin
              r = run_q.pop_front();
              chk("fin_latency", 32'(cyc - reset_cyc), 32'(r.fin_lat));
              chk("sweep_pulses", 32'(sweeps), 32'(r.sweeps));
              chk("run_cycles", run_cycles, r.runcyc);
            end
          end
        end
        prev_st = state;
        dwell = 1;
      end else begin
        dwell++;
      end
    end
  end

  task automatic do_run(logic [15:0] im, int sweeps, int fin_lat);
    iter_max = im;
    push_run(sweeps, fin_lat);
    start = 1'b1;
    wait_state(S_FIN, 2000, "fin");
    repeat (3) @(negedge clk);
    chk("done_held", 32'(done), 32'd1);
    start = 1'b0;
    wait_state(S_IDLE, 10, "idle");
    @(negedge clk);
  endtask

  initial begin
    rst_sys = 1'b0; start = 1'b0; abort = 1'b0; iter_max = 16'd1;
    #3;
    chk("reset_state", 32'(state), 32'(S_IDLE));
    chk("reset_decodes", 32'({busy, done, acc_clr, acc_en, spin_we, sweep_done}), 32'd0);
    chk("reset_run_cycles", run_cycles, 32'd0);
    repeat (2) @(negedge clk);
    rst_sys = 1'b1;
    @(negedge clk);

    // Two sweeps: 4 + 2*34 cycles.
    do_run(16'd2, 2, 72);
    // Zero budget behaves as one sweep: 4 + 34.
    do_run(16'd0, 1, 38);
    do_run(16'd1, 1, 38);

    // Abort in MULT, then a clean run.
    iter_max = 16'd1;
    push(S_RESET, NN); push(S_STMULT, 1); push(S_MULT, -1); push(S_IDLE, -1);
    start = 1'b1;
    wait_state(S_MULT, 50, "mult");
    abort = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(state), 32'(S_IDLE));
    abort = 1'b0;
    @(negedge clk);
    do_run(16'd1, 1, 38);

    // Asynchronous reset mid-UPDATE.
    push(S_RESET, NN); push_spin_upto_update(-1); push(S_IDLE, -1);
    start = 1'b1;
    wait_state(S_UPDATE, 100, "update");
    #2;
    rst_sys = 1'b0;
    start = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'(S_IDLE));
    chk("async_rst_decodes", 32'({busy, done, acc_clr, acc_en, spin_we, sweep_done}), 32'd0);
    chk("async_rst_run_cycles", run_cycles, 32'd0);
    @(negedge clk);
    rst_sys = 1'b1;
    repeat (3) @(negedge clk);

    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("run_queue_drained", 32'(run_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded expected finish");
    $fatal(1, "timeout");
  end
endmodule
